// File: rtl/proteus_pkg.sv
// Shared definitions for the Proteus packing datapath: default widths,
// packer FSM state type and the fill-count width helper.
package proteus_pkg;

   localparam int BIT_WIDTH_DEF = 16;
   localparam int PREC_BITS_DEF = 5;

   typedef enum logic {
      FILL  = 1'b0,
      FLUSH = 1'b1
   } packer_state_t;

   // Fill count spans 0..2*BIT_WIDTH-1, one bit wider than the precision field.
   function automatic int cnt_width(input int prec_bits);
      return prec_bits + 1;
   endfunction

   localparam int CNT_W_DEF = PREC_BITS_DEF + 1;

endpackage

// File: rtl/stream_packer_shifter.sv
// Logarithmic left barrel shifter used to align incoming words at the
// current fill position of the packing register.
module shifter #(
   parameter int WIDTH = 32,
   parameter int CTRL  = 6
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [CTRL-1:0]  i_shamt,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] w_stage [CTRL+1];

   assign w_stage[0] = i_data;

   for (genvar k = 0; k < CTRL; k++) begin : g_stage
      assign w_stage[k+1] = i_shamt[k] ? (w_stage[k] << (1 << k)) : w_stage[k];
   end

   assign o_data = w_stage[CTRL];

endmodule

// File: rtl/stream_packer.sv
// Variable-precision stream packer: concatenates the low p bits of each word
// into BIT_WIDTH rows with flush/last. Optional STREAM_PACKER_ROWCNT_EN adds row/pad counters.
//
// state | meaning
// FILL  | accepting words, emitting full rows
// FLUSH | draining buffered bits, final row zero-padded and marked last
module stream_packer
   import proteus_pkg::*;
#(
   parameter int BIT_WIDTH = BIT_WIDTH_DEF,
   parameter int PREC_BITS = PREC_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BIT_WIDTH-1:0] i_in,
   input  logic [PREC_BITS-1:0] i_prec,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_flush,
   output logic [BIT_WIDTH-1:0] o_out,
   output logic                 o_valid,
   output logic                 o_last,
   input  logic                 i_out_ready
`ifdef STREAM_PACKER_ROWCNT_EN
   ,
   output logic [31:0]          o_row_count,
   output logic [PREC_BITS:0]   o_pad_bits
`endif
);

   localparam int RW = 2 * BIT_WIDTH;
   localparam int CW = cnt_width(PREC_BITS);
   localparam logic [CW-1:0] BW_C = CW'(BIT_WIDTH);

   packer_state_t r_state, w_state_nxt;
   logic [RW-1:0] r_pack;
   logic [CW-1:0] r_cnt;

   logic          w_full, w_pop, w_acc;
   logic [RW-1:0] w_base_r, w_in_ext, w_in_aligned, w_r_nxt;
   logic [CW-1:0] w_base_cnt, w_cnt_nxt;

   assign w_full = (r_cnt >= BW_C);
   assign w_pop  = o_valid && i_out_ready;
   assign w_acc  = i_valid && o_ready;

   // Post-pop view of the register; an accepted word lands on top of this.
   always_comb begin
      w_base_r   = r_pack;
      w_base_cnt = r_cnt;
      if (w_pop) begin
         if (w_full) begin
            w_base_r   = {{BIT_WIDTH{1'b0}}, r_pack[RW-1:BIT_WIDTH]};
            w_base_cnt = r_cnt - BW_C;
         end else begin
            w_base_r   = '0;
            w_base_cnt = '0;
         end
      end
   end

   assign w_in_ext = {{BIT_WIDTH{1'b0}}, i_in} & ~({RW{1'b1}} << i_prec);

   shifter #(
      .WIDTH (RW),
      .CTRL  (CW)
   ) u_align (
      .i_data  (w_in_ext),
      .i_shamt (w_base_cnt),
      .o_data  (w_in_aligned)
   );

   assign w_r_nxt   = w_base_r | (w_acc ? w_in_aligned : '0);
   assign w_cnt_nxt = w_base_cnt + (w_acc ? CW'(i_prec) : '0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= FILL;
      else     r_state <= w_state_nxt;
   end

   // A flush that would leave nothing buffered is dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL:    if (i_flush && (w_cnt_nxt != '0)) w_state_nxt = FLUSH;
         FLUSH:   if (w_pop && (w_cnt_nxt == '0))   w_state_nxt = FILL;
         default: w_state_nxt = FILL;
      endcase
   end

   always_comb begin
      o_valid = w_full || ((r_state == FLUSH) && (r_cnt != '0));
      o_ready = (r_state == FILL) && (!w_full || i_out_ready);
      o_last  = (r_state == FLUSH) && (r_cnt <= BW_C);
   end

   assign o_out = r_pack[BIT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pack <= '0;
         r_cnt  <= '0;
      end else begin
         r_pack <= w_r_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

`ifdef STREAM_PACKER_ROWCNT_EN
   logic [31:0] r_row_count;
   logic [CW-1:0] r_pad_bits;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_count <= '0;
         r_pad_bits  <= '0;
      end else begin
         if (w_pop) r_row_count <= r_row_count + 32'd1;
         if (w_pop && o_last) r_pad_bits <= BW_C - r_cnt;
      end
   end

   assign o_row_count = r_row_count;
   assign o_pad_bits  = r_pad_bits;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: directed table, corner sequences and
// randomized traffic compared against a bit-queue reference model.
module tb_stream_packer;

   localparam int BW = 16;
   localparam int PB = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] i_in;
   logic [PB-1:0] i_prec;
   logic          i_valid;
   logic          o_ready;
   logic          i_flush;
   logic [BW-1:0] o_out;
   logic          o_valid;
   logic          o_last;
   logic          i_out_ready;
`ifdef STREAM_PACKER_ROWCNT_EN
   logic [31:0]   o_row_count;
   logic [PB:0]   o_pad_bits;
`endif

   stream_packer #(.BIT_WIDTH(BW), .PREC_BITS(PB)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_in        (i_in),
      .i_prec      (i_prec),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_flush     (i_flush),
      .o_out       (o_out),
      .o_valid     (o_valid),
      .o_last      (o_last),
      .i_out_ready (i_out_ready)
`ifdef STREAM_PACKER_ROWCNT_EN
      ,
      .o_row_count (o_row_count),
      .o_pad_bits  (o_pad_bits)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && i_valid) assert (i_prec <= PB'(BW)) else $error("illegal precision %0d", i_prec);
   end

   int checks = 0;
   int errors = 0;

   // Reference model: buffered bits in arrival order, plus a draining flag.
   bit mq[$];
   bit mflush;

   typedef struct {
      logic          v;
      logic [BW-1:0] d;
      logic [PB-1:0] p;
      logic          f;
      logic          ordy;
      logic          ev;
      logic [BW-1:0] eo;
      logic          el;
      logic          er;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] m_row();
      logic [BW-1:0] x = '0;
      for (int i = 0; i < BW; i++) if (i < mq.size()) x[i] = mq[i];
      return x;
   endfunction

   function automatic bit m_valid();
      return (mq.size() >= BW) || (mflush && mq.size() > 0);
   endfunction

   function automatic bit m_ready();
      return !mflush && ((mq.size() < BW) || i_out_ready);
   endfunction

   task automatic apply(input logic v, input logic [BW-1:0] d, input logic [PB-1:0] p,
                        input logic f, input logic ordy);
      i_valid = v; i_in = d; i_prec = p; i_flush = f; i_out_ready = ordy;
      #1;
   endtask

   task automatic tick();
      bit mv, pop, acc, fl;
      int n;
      mv = m_valid();
      chk("model_valid", o_valid, mv);
      chk("model_ready", o_ready, m_ready());
      if (mv) begin
         chk("model_out", o_out, m_row());
         chk("model_last", o_last, mflush && (mq.size() <= BW));
      end
      pop = mv && i_out_ready;
      acc = i_valid && m_ready();
      fl  = i_flush;
      @(posedge clk);
      if (pop) begin
         n = (mq.size() < BW) ? mq.size() : BW;
         repeat (n) void'(mq.pop_front());
      end
      if (acc) for (int k = 0; k < int'(i_prec); k++) mq.push_back(i_in[k]);
      if (mflush) begin
         if (pop && mq.size() == 0) mflush = 1'b0;
      end else if (fl && mq.size() > 0) begin
         mflush = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic reset_cycle(input logic f);
      rst = 1'b1;
      i_valid = 1'b0; i_in = '0; i_prec = '0; i_flush = f; i_out_ready = 1'b0;
      @(posedge clk);
      mq.delete();
      mflush = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      i_flush = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 16'h000A, 5'd4, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 16'h000B, 5'd4, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 16'h000C, 5'd4, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 16'h000D, 5'd4, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b1, 16'hDCBA, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 16'h001F, 5'd5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 16'h001F, 5'd5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 16'h001F, 5'd5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 16'h001F, 5'd5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

      mflush = 1'b0;
      rst = 1'b1;
      i_valid = 1'b0; i_in = '0; i_prec = '0; i_flush = 1'b0; i_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_last", o_last, 1'b0);
      chk("rst_out", o_out, 16'h0);
      chk("rst_ready", o_ready, 1'b1);
      tick();

      // Directed table: p=4 row, p=5 row with residual and flush
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].ordy);
         chk("tbl_valid", o_valid, tbl[i].ev);
         chk("tbl_ready", o_ready, tbl[i].er);
         if (tbl[i].ev) begin
            chk("tbl_out", o_out, tbl[i].eo);
            chk("tbl_last", o_last, tbl[i].el);
         end
         tick();
      end

      // Backpressure hold, then pop and accept together
      apply(1'b1, 16'hBEEF, 5'd16, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
         chk("hold_valid", o_valid, 1'b1);
         chk("hold_out", o_out, 16'hBEEF);
         chk("hold_ready", o_ready, 1'b0);
         tick();
      end
      apply(1'b1, 16'h1234, 5'd16, 1'b0, 1'b1);
      chk("pa_ready", o_ready, 1'b1);
      chk("pa_first", o_out, 16'hBEEF);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("pa_second", o_out, 16'h1234);
      chk("pa_valid", o_valid, 1'b1);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("pa_empty", o_valid, 1'b0);
      tick();

      // Full-width back-to-back throughput
      for (int k = 0; k < 8; k++) begin
         apply(1'b1, 16'(k), 5'd16, 1'b0, 1'b1);
         chk("b2b_ready", o_ready, 1'b1);
         if (k > 0) begin
            chk("b2b_valid", o_valid, 1'b1);
            chk("b2b_out", o_out, 16'(k - 1));
         end
         tick();
      end
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("b2b_tail", o_out, 16'h0007);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("b2b_empty", o_valid, 1'b0);
      tick();

      // Empty flush is a no-op; flush with same-cycle accept
      apply(1'b0, 16'h0, 5'd0, 1'b1, 1'b1);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("eflush_valid", o_valid, 1'b0);
      chk("eflush_ready", o_ready, 1'b1);
      tick();
      apply(1'b1, 16'h0005, 5'd3, 1'b1, 1'b1);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("fa_valid", o_valid, 1'b1);
      chk("fa_out", o_out, 16'h0005);
      chk("fa_last", o_last, 1'b1);
      chk("fa_ready", o_ready, 1'b0);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("fa_empty", o_valid, 1'b0);
      chk("fa_ready2", o_ready, 1'b1);
      tick();

      // Reset mid-stream with 12 bits buffered and a flush pending
      for (int k = 1; k <= 3; k++) begin
         apply(1'b1, 16'(k), 5'd4, 1'b0, 1'b0);
         tick();
      end
      apply(1'b0, 16'h0, 5'd0, 1'b1, 1'b0);
      tick();
      reset_cycle(1'b1);
      apply(1'b1, 16'h1234, 5'd16, 1'b0, 1'b1);
      chk("mrst_valid", o_valid, 1'b0);
      chk("mrst_ready", o_ready, 1'b1);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("mrst_valid2", o_valid, 1'b1);
      chk("mrst_out", o_out, 16'h1234);
      chk("mrst_last", o_last, 1'b0);
      tick();
      apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
      chk("mrst_empty", o_valid, 1'b0);
      tick();

      // Randomized traffic against the bit-queue model
      for (int c = 0; c < 3000; c++) begin
         apply($urandom_range(0, 3) != 0, 16'($urandom), 5'($urandom_range(0, BW)),
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
         tick();
      end
      // Drain whatever is left through a flush
      apply(1'b0, 16'h0, 5'd0, 1'b1, 1'b1);
      tick();
      for (int c = 0; c < 6; c++) begin
         apply(1'b0, 16'h0, 5'd0, 1'b0, 1'b1);
         tick();
      end
      chk("final_drained", o_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
